// File: rtl/multi_pattern_gen_pkg.sv
// Shared types and constants for the multi-channel pattern generator.
package multi_pattern_gen_pkg;

  typedef enum logic [1:0] {
    INCR = 2'd0,
    DECR = 2'd1,
    LFSR = 2'd2,
    HOLD = 2'd3
  } mode_e;

  localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

  // Channel index width; never narrower than one bit so a 1-channel build still has an out_ch port.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_chan.sv
// One generator channel: free-running reload timer, pattern value and pending flag.
module pattern_chan
  import multi_pattern_gen_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                PERIOD_W  = 8,
  parameter int                TIMER_W   = 10,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEFAULT_LFSR_TAPS),
  parameter int                IDX       = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DATA_W-1:0]   seed,
  input  logic                grant,
  output logic [DATA_W-1:0]   value,
  output logic                pending,
  output logic                overrun_set
);

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] reload;
  logic [DATA_W-1:0]  nxt_value;
  logic               tick;

  // Each channel runs one cycle slower than its lower neighbour, which staggers the ticks.
  assign reload      = TIMER_W'(period) + TIMER_W'(IDX);
  assign tick        = enable && (timer == '0);
  // A grant in the tick cycle drains the old beat, so the new one is not an overrun.
  assign overrun_set = tick && pending && !grant;

  always_comb begin
    nxt_value = value;
    case (mode_e'(mode))
      INCR:    nxt_value = value + DATA_W'(1);
      DECR:    nxt_value = value - DATA_W'(1);
      LFSR:    nxt_value = (value == '0) ? DATA_W'(1)
                         : ((value >> 1) ^ (value[0] ? LFSR_TAPS : '0));
      default: nxt_value = value;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer   <= reload;
      value   <= seed + DATA_W'(IDX);
      pending <= 1'b0;
    end else begin
      if (enable) timer <= tick ? reload : timer - TIMER_W'(1);
      if (tick) value <= nxt_value;
      if (tick) pending <= 1'b1;
      else if (grant) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_pattern_gen.sv
// NUM_CH pattern channels sharing one valid/ready output through a round-robin arbiter.
module multi_pattern_gen
  import multi_pattern_gen_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                DATA_W    = 8,
  parameter int                PERIOD_W  = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [PERIOD_W-1:0]       period,
  input  logic [DATA_W-1:0]         seed,
  output logic [DATA_W-1:0]         out_data,
  output logic [ch_w(NUM_CH)-1:0]   out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      clear_overrun,
  output logic [NUM_CH-1:0]         overrun
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0][DATA_W-1:0] ch_value;
  logic [NUM_CH-1:0]             ch_pending;
  logic [NUM_CH-1:0]             ch_ovr_set;
  logic [NUM_CH-1:0]             grant;
  logic [CH_W-1:0]               rr_ptr;
  logic [CH_W-1:0]               gnt_idx;
  logic                          gnt_any;
  logic                          loadable;
  int                            cand;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pattern_chan #(
      .DATA_W   (DATA_W),
      .PERIOD_W (PERIOD_W),
      .TIMER_W  (PERIOD_W + CH_W),
      .LFSR_TAPS(LFSR_TAPS),
      .IDX      (i)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .period     (period),
      .seed       (seed),
      .grant      (grant[i]),
      .value      (ch_value[i]),
      .pending    (ch_pending[i]),
      .overrun_set(ch_ovr_set[i])
    );
  end

  assign loadable = !out_valid || out_ready;

  // Search starts just past the last winner so every pending channel is served in turn.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    cand    = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!gnt_any && ch_pending[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  assign grant = (gnt_any && loadable) ? (NUM_CH'(1) << gnt_idx) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= CH_W'(NUM_CH - 1);
      overrun   <= '0;
    end else begin
      if (loadable) begin
        if (gnt_any) begin
          out_data  <= ch_value[gnt_idx];
          out_ch    <= gnt_idx;
          out_valid <= 1'b1;
          rr_ptr    <= gnt_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
      overrun <= (clear_overrun ? '0 : overrun) | ch_ovr_set;
    end
  end

endmodule

// File: doc/multi_pattern_gen.md
MULTI_PATTERN_GEN -- requirements
Module: multi_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent generator channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 8: data width per channel.
REQ-003 SHALL have parameter PERIOD_W, default 8: width of the period input.
REQ-004 SHALL have parameter LFSR_TAPS, default 8'hB8: Galois feedback mask, width DATA_W.
REQ-005 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: timers run while high, freeze while low.
REQ-008 SHALL have port mode, input, 2: 0 INCR, 1 DECR, 2 LFSR, 3 HOLD; applied at each tick.
REQ-009 SHALL have port period, input, PERIOD_W: base reload value.
REQ-010 SHALL have port seed, input, DATA_W: channel value base at reset.
REQ-011 SHALL have port out_data, output, DATA_W: granted channel value.
REQ-012 SHALL have port out_ch, output, CH_W = max(1,clog2(NUM_CH)): granted channel index.
REQ-013 SHALL have port out_valid, output, 1: beat available.
REQ-014 SHALL have port out_ready, input, 1: sink accepts beat when high together with out_valid.
REQ-015 SHALL have port clear_overrun, input, 1: clears all overrun flags.
REQ-016 SHALL have port overrun, output, NUM_CH: sticky per-channel overrun flags.

Function
REQ-017 Each channel i SHALL hold a down-counter timer_i of width PERIOD_W+CH_W, decremented once per cycle while enable=1 and held while enable=0.
REQ-018 When timer_i==0 with enable=1, the channel SHALL tick: reload timer_i with period+i, so its tick interval is period+i+1 cycles; period=0 on channel 0 ticks every cycle.
REQ-019 A tick SHALL update value_i per mode:
- INCR: +1, modulo 2^DATA_W.
- DECR: -1, modulo 2^DATA_W.
- LFSR: right shift XOR LFSR_TAPS when LSB=1; a value of 0 becomes 1.
- HOLD: unchanged.
REQ-020 A tick SHALL set pending_i; a tick while pending_i is already set SHALL set overrun_i, still update value_i, and keep pending_i set.
REQ-021 The output register SHALL be loadable when out_valid=0 or out_valid&out_ready.
REQ-022 When loadable and any pending_i is set, the block SHALL grant round-robin, starting at last granted index+1 and wrapping at NUM_CH.
REQ-023 A grant SHALL load out_data=value_i and out_ch=i, assert out_valid, and clear pending_i.
REQ-024 When loadable and nothing is pending, out_valid SHALL deassert.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_ch SHALL be held stable.
REQ-026 Latency SHALL be as follows: a tick in cycle t gives pending in t+1, and earliest out_valid in t+2.
REQ-027 Tick and grant of the same channel in the same cycle SHALL output the pre-tick value, leave pending_i set with the new value, and not set overrun_i.
REQ-028 clear_overrun SHALL zero all overrun bits; a simultaneous overrun set on a channel SHALL win for that channel.
REQ-029 Changes to period or mode SHALL take effect only at each channel's next reload or tick; they SHALL NOT alter a timer mid-count.

Reset
REQ-030 In any cycle with reset=1, the block SHALL load:
- out_valid=0, out_data=0, out_ch=0, overrun=0, all pending=0.
- timer_i=period+i, value_i=seed+i (mod 2^DATA_W).
- round-robin pointer=NUM_CH-1, so channel 0 is granted first.
REQ-031 Reset SHALL override enable, out_ready and clear_overrun, and SHALL discard any beat in flight.

Structure
REQ-032 Package multi_pattern_gen_pkg SHALL hold the mode enum typedef (INCR/DECR/LFSR/HOLD), the default LFSR taps constant and the CH_W width function.
REQ-033 Per-channel timer, value and pending logic SHALL be a sub-module pattern_chan, generated NUM_CH times; arbiter and output register SHALL live in the top.

Verification
REQ-034 Scenario (defaults, period=3, seed=0x10, INCR, out_ready=1): first beats SHALL be ch0 0x11, ch1 0x12, ch2 0x13, ch3 0x14 in order; ch0 SHALL repeat every 4 cycles.
REQ-035 Scenario (period=0, out_ready=0 for 40 cycles): out_data SHALL stay stable and overrun[0]=1; after out_ready=1, each beat SHALL be accepted once; clear_overrun SHALL then return overrun to 0.
REQ-036 Scenario (seed=0x00, LFSR): the ch0 first beat SHALL be 0x01, the next 0xB8, then 0x5C.
REQ-037 Scenario (enable=0 for 20 cycles mid-count): no new ticks SHALL occur; the timer SHALL resume from its held value.
REQ-038 Scenario (reset during out_valid=1, out_ready=0): the next cycle SHALL show out_valid=0 and overrun=0, and ch0 SHALL be granted first afterwards.
REQ-039 Scenario (ch1 tick coinciding with its grant): the output SHALL carry the old value, a second ch1 beat SHALL carry the new value, and overrun[1] SHALL stay 0.
